// File: rtl/mux_sel_pipe.sv
// mux_sel_pipe: registered N-channel selector (In/Sel/Mode/InValid in, InReady/Out/OutSel/OutValid/Err out) with round-robin scan and out-of-range flag
module mux_sel_pipe #(
  parameter int WIDTH = 16,
  parameter int N = 4,
  parameter int SELW = 2
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [N*WIDTH-1:0] In,
  input  logic [SELW-1:0]    Sel,
  input  logic               Mode,
  input  logic               InValid,
  output logic               InReady,
  output logic [WIDTH-1:0]   Out,
  output logic [SELW-1:0]    OutSel,
  output logic               OutValid,
  input  logic               OutReady,
  output logic               Err
);
  localparam logic [SELW:0] LAST = (SELW+1)'(N-1);
  logic [SELW-1:0] ptr, eff, ptr_nxt;
  logic [WIDTH-1:0] data;
  logic accept, oor;
  assign InReady = !OutValid || OutReady;
  assign accept = InValid && InReady;
  assign eff = Mode ? ptr : Sel;
  assign oor = {1'b0, eff} > LAST;
  assign ptr_nxt = ({1'b0, eff} >= LAST) ? '0 : eff + SELW'(1);
  always_comb begin
    data = '0;
    for (int i = 0; i < N; i++) data = (eff == SELW'(i)) ? In[i*WIDTH +: WIDTH] : data;
  end
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      Out <= '0;
      OutSel <= '0;
      OutValid <= 1'b0;
      Err <= 1'b0;
      ptr <= '0;
    end else if (accept) begin
      Out <= data;
      OutSel <= eff;
      OutValid <= 1'b1;
      Err <= oor;
      ptr <= ptr_nxt;
    end else if (OutReady) OutValid <= 1'b0;
endmodule

// File: tb/tb_mux_sel_pipe.sv
// tb_mux_sel_pipe: directed and randomized checks of mux_sel_pipe (N=4 and N=3) against a behavioural model
module tb_mux_sel_pipe;
  logic clk = 0, rst = 0;
  logic [63:0] in_bus;
  logic [1:0] sel;
  logic mode, ivalid, ordy;
  logic r4, r3, v4, v3, e4, e3;
  logic [15:0] o4, o3;
  logic [1:0] s4, s3;
  int compared = 0, mismatched = 0;
  bit chk_en = 0;
  int nch [2] = '{4, 3};
  logic [15:0] m_out [2];
  logic [1:0] m_sel [2];
  bit m_v [2], m_err [2];
  int m_ptr [2];
  always #5 clk = ~clk;
  mux_sel_pipe #(.WIDTH(16), .N(4), .SELW(2)) u4 (
    .CLK(clk), .Reset(rst), .In(in_bus), .Sel(sel), .Mode(mode), .InValid(ivalid),
    .InReady(r4), .Out(o4), .OutSel(s4), .OutValid(v4), .OutReady(ordy), .Err(e4));
  mux_sel_pipe #(.WIDTH(16), .N(3), .SELW(2)) u3 (
    .CLK(clk), .Reset(rst), .In(in_bus[47:0]), .Sel(sel), .Mode(mode), .InValid(ivalid),
    .InReady(r3), .Out(o3), .OutSel(s3), .OutValid(v3), .OutReady(ordy), .Err(e3));
  function automatic int eff_of(input int k);
    return mode ? m_ptr[k] : int'(sel);
  endfunction
  always @(posedge clk or posedge rst)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        m_out[k] <= 0;
        m_sel[k] <= 0;
        m_v[k] <= 0;
        m_err[k] <= 0;
        m_ptr[k] <= 0;
      end else if (ivalid && (!m_v[k] || ordy)) begin
        m_sel[k] <= 2'(eff_of(k));
        m_v[k] <= 1;
        m_err[k] <= eff_of(k) >= nch[k];
        m_out[k] <= (eff_of(k) >= nch[k]) ? 16'h0 : 16'(in_bus >> (16 * eff_of(k)));
        m_ptr[k] <= (eff_of(k) >= nch[k]) ? 0 : (eff_of(k) + 1) % nch[k];
      end else if (ordy) m_v[k] <= 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (chk_en) begin
      check("u4.Out", o4, m_out[0]);
      check("u4.OutSel", s4, m_sel[0]);
      check("u4.OutValid", v4, m_v[0]);
      check("u4.Err", e4, m_err[0]);
      check("u4.InReady", r4, !m_v[0] || ordy);
      check("u3.Out", o3, m_out[1]);
      check("u3.OutSel", s3, m_sel[1]);
      check("u3.OutValid", v3, m_v[1]);
      check("u3.Err", e3, m_err[1]);
      check("u3.InReady", r3, !m_v[1] || ordy);
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1;
    step();
    step();
    rst = 0;
  endtask
  int exp_sel [6] = '{0, 1, 2, 3, 0, 1};
  int exp_out [6] = '{1, 2, 4, 8, 1, 2};
  int exp_d [4] = '{8, 4, 2, 1};
  initial begin
    in_bus = 64'h0008_0004_0002_0001;
    sel = 0;
    mode = 0;
    ivalid = 0;
    ordy = 1;
    do_reset();
    chk_en = 1;
    check("reset u4.Out", o4, 0);
    check("reset u4.OutValid", v4, 0);
    check("reset u4.OutSel", s4, 0);
    check("reset u3.Err", e3, 0);
    ivalid = 1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(3 - i);
      step();
      check("direct u4.Out", o4, exp_d[i]);
      check("direct u4.OutSel", s4, 3 - i);
      check("direct u4.OutValid", v4, 1);
      check("direct u4.Err", e4, 0);
    end
    do_reset();
    mode = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("scan u4.OutSel", s4, exp_sel[i]);
      check("scan u4.Out", o4, exp_out[i]);
    end
    do_reset();
    mode = 0;
    sel = 2;
    step();
    check("bp u4.Out first", o4, 4);
    ordy = 0;
    sel = 0;
    #1;
    check("bp u4.InReady", r4, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp u4.Out held", o4, 4);
      check("bp u4.OutSel held", s4, 2);
      check("bp u4.OutValid held", v4, 1);
      check("bp u4.InReady stalled", r4, 0);
    end
    ordy = 1;
    step();
    check("bp u4.Out release", o4, 1);
    do_reset();
    sel = 3;
    step();
    check("oor u3.Out", o3, 0);
    check("oor u3.Err", e3, 1);
    check("oor u3.OutSel", s3, 3);
    sel = 1;
    step();
    check("oor clear u3.Err", e3, 0);
    check("oor clear u3.Out", o3, 2);
    mode = 1;
    step();
    check("oor scan u3.OutSel", s3, 2);
    check("oor scan u3.Out", o3, 4);
    do_reset();
    mode = 0;
    sel = 1;
    step();
    check("handoff u4.OutSel 0", s4, 1);
    mode = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("handoff u4.OutSel", s4, (i + 2) % 4);
    end
    do_reset();
    mode = 0;
    sel = 3;
    step();
    ordy = 0;
    step();
    rst = 1;
    #1;
    check("async u4.OutValid", v4, 0);
    check("async u4.Out", o4, 0);
    check("async u3.Err", e3, 0);
    check("async u3.OutValid", v3, 0);
    rst = 0;
    mode = 1;
    ordy = 1;
    step();
    check("restart u4.OutSel", s4, 0);
    check("restart u3.OutSel", s3, 0);
    check("restart u4.Out", o4, 1);
    for (int c = 0; c < 3000; c++) begin
      ivalid = $urandom_range(0, 3) != 0;
      ordy = $urandom_range(0, 2) != 0;
      sel = 2'($urandom);
      mode = ($urandom_range(0, 7) == 0) ? ~mode : mode;
      in_bus = {$urandom, $urandom};
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    rst = 0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
